stall_engine_n: RTL and testbench
=================================

# stall_engine_n

Parametrised pipeline stall engine for a STAGES-deep in-order pipeline.
- Tracks per-stage full bits.
- Resolves per-stage hazards into back-propagating stall and per-stage update enables.
- Squashes stages on a per-stage flush mask.
- Runs a drain/halt/resume FSM for debug and exception entry.
- Keeps saturating stall and bubble performance counters.

It sits in pipeline_control between the hazard units and the datapath pipeline registers.

## Interface
- STAGES, 5, pipeline depth, ≥2; bit 0 = fetch, bit STAGES-1 = retire
- CNT_W, 32, performance counter width, ≥2

- clk  in  1  clock; all state on posedge
- rst_n  in  1  asynchronous, active-low reset
- haz  in  STAGES  per-stage hazard request (stage k cannot advance this cycle)
- flush  in  STAGES  per-stage squash mask, applied at next edge
- drain_req  in  1  stop fetch and empty pipeline
- resume  in  1  leave HALTED
- cnt_clr  in  1  synchronous clear of both counters
- full  out  STAGES  stage k holds a valid instruction (registered)
- stall  out  STAGES  stage k held this cycle (combinational)
- ue  out  STAGES  stage k advances / its register updates this cycle (combinational)
- state  out  2  FSM state, RUN/DRAIN/HALTED
- drained  out  1  state==HALTED
- stall_cycles  out  CNT_W  cycles with any stall bit set
- bubble_cycles  out  CNT_W  RUN cycles with retire stage empty

## Operation
- eff[k] = full[k] & ~flush[k]. Flushed stages never stall and never advance.
- Stall chain: stall[STAGES-1] = eff[STAGES-1] & haz[STAGES-1]; stall[k] = eff[k] & (haz[k] | stall[k+1]).
- Hazards on empty or flushed stages are ignored.
- ue[k] = eff[k] & ~stall[k].
- Next full:
  - full'[0] = stall[0] | (state==RUN)
  - full'[k] = ue[k-1] | stall[k], for k≥1
- A stage behind a stall that advances leaves a bubble.
- flush is not prefix-expanded. The issuing unit supplies the complete mask.
- FSM:
  - RUN → DRAIN on drain_req.
  - DRAIN → HALTED when eff == 0.
  - HALTED → RUN on resume.
  - resume in RUN or DRAIN: ignored. drain_req in DRAIN or HALTED: ignored.
  - Simultaneous drain_req and resume in HALTED: resume wins.
- Fetch (full'[0]) uses the current registered state. The edge that samples drain_req still fetches.
- Counters:
  - Unsigned, saturate at 2^CNT_W−1; never wrap.
  - stall_cycles increments on |stall.
  - bubble_cycles increments when state==RUN and full[STAGES-1]==0.
  - cnt_clr has priority over increment; the counter reads 0 after the edge.

## Timing
- Reset (rst_n low, asynchronous): full=0, state=RUN, both counters 0. Hence stall=0, ue=0, drained=0.
- stall and ue respond combinationally to haz, flush and full in the same cycle. No registered path from haz to stall.
- full, state and the counters change only on posedge clk.
- Fill latency, no hazards: full[k] first high after edge k+1 following reset release.
- Drain latency from DRAIN entry with full all-ones: STAGES edges to empty, plus 1 edge to HALTED.
- Reset mid-drain or mid-stall: immediate return to reset values. No pending drain is remembered.

## Structure
- Shared package pipe_ctrl_pkg:
  - pipe_state_e enum: RUN=2'd0, DRAIN=2'd1, HALTED=2'd2.
  - 2'd3 is illegal; it recovers to RUN on the next edge.
- Sub-module sat_counter (#(W) clk, rst_n, clr, inc, q), instantiated twice.
- Stall chain and full update are generate loops over STAGES.

## Test plan
- Release reset, no haz, STAGES=5 → full 00001, 00011, 00111, 01111, 11111 after edges 1-5; bubble_cycles=5 after edge 5.
- full=11111, haz[2]=1 for 2 cycles → stall=00111, ue=11000; full 10111, then 00111; stall_cycles=2; refill after haz drops.
- full=11111, flush=00011, no haz → next full=11001; stall stays 0 even with haz[1]=1 in the same cycle.
- full=11111, one-cycle drain_req → state=DRAIN at edge 1; full 11110, 11100, 11000, 10000, 00000 at edges 2-6; drained=1 at edge 7. resume → RUN next edge, full=00001 one edge later.
- CNT_W=4, haz[4]=1 held 20 cycles with full[4]=1 → stall_cycles=15 (saturated); cnt_clr together with stall → 0 after the edge.
- Drop rst_n between edges while stalled in DRAIN → full=0, state=RUN, counters 0 without a clock edge; normal fill resumes after release.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: FSM state encoding for the stall engine.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/sat_counter.sv
// Unsigned saturating event counter with synchronous clear taking priority.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/stall_engine_n.sv
// Pipeline stall engine: full tracking, hazard-to-stall chain, flush squash,
// drain/halt/resume FSM and saturating stall/bubble counters.
module stall_engine_n
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STAGES = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [STAGES-1:0] haz,
  input  logic [STAGES-1:0] flush,
  input  logic              drain_req,
  input  logic              resume,
  input  logic              cnt_clr,
  output logic [STAGES-1:0] full,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] ue,
  output logic [1:0]        state,
  output logic              drained,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  bubble_cycles
);

  pipe_state_e       state_q;
  logic [STAGES-1:0] full_q;
  logic [STAGES-1:0] full_d;
  logic [STAGES-1:0] eff;

  assign eff = full_q & ~flush;

  // Stage k stalls if some hazard at j>=k is reachable through an unbroken run of
  // occupied stages; the unrolled form keeps each bit free of feedback on the vector.
  for (genvar g = 0; g < STAGES; g++) begin : g_stall
    logic hold;
    logic run;
    always_comb begin
      hold = 1'b0;
      run  = 1'b1;
      for (int j = g; j < STAGES; j++) begin
        run  = run & eff[j];
        hold = hold | (run & haz[j]);
      end
    end
    assign stall[g] = hold;
  end

  assign ue = eff & ~stall;

  for (genvar g = 0; g < STAGES; g++) begin : g_full
    if (g == 0) begin : g_fetch
      assign full_d[g] = stall[g] | (state_q == RUN);
    end else begin : g_body
      assign full_d[g] = ue[g-1] | stall[g];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= '0;
      state_q <= RUN;
    end else begin
      full_q <= full_d;
      case (state_q)
        RUN:     if (drain_req) state_q <= DRAIN;
        DRAIN:   if (eff == '0) state_q <= HALTED;
        HALTED:  if (resume) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  assign full    = full_q;
  assign state   = state_q;
  assign drained = (state_q == HALTED);

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (|stall),
    .q     (stall_cycles)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   ((state_q == RUN) && !full_q[STAGES-1]),
    .q     (bubble_cycles)
  );

endmodule

// File: tb/tb_stall_engine_n.sv
// Scoreboard bench for stall_engine_n (STAGES=5, CNT_W=4): directed stimulus queues
// expected outputs per cycle; a negedge monitor pops and compares them.
module tb_stall_engine_n;

  localparam int unsigned STAGES = 5;
  localparam int unsigned CNT_W  = 4;

  localparam int F_FULL    = 0;
  localparam int F_STALL   = 1;
  localparam int F_UE      = 2;
  localparam int F_STATE   = 3;
  localparam int F_DRAINED = 4;
  localparam int F_SC      = 5;
  localparam int F_BC      = 6;

  logic              clk;
  logic              rst_n;
  logic [STAGES-1:0] haz;
  logic [STAGES-1:0] flush;
  logic              drain_req;
  logic              resume;
  logic              cnt_clr;
  logic [STAGES-1:0] full;
  logic [STAGES-1:0] stall;
  logic [STAGES-1:0] ue;
  logic [1:0]        state;
  logic              drained;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  bubble_cycles;

  stall_engine_n #(
    .STAGES (STAGES),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .haz           (haz),
    .flush         (flush),
    .drain_req     (drain_req),
    .resume        (resume),
    .cnt_clr       (cnt_clr),
    .full          (full),
    .stall         (stall),
    .ue            (ue),
    .state         (state),
    .drained       (drained),
    .stall_cycles  (stall_cycles),
    .bubble_cycles (bubble_cycles)
  );

  typedef struct {
    int          cyc;
    string       name;
    int          field;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        mon_e;
  logic [31:0] mon_act;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] read_field(input int field);
    case (field)
      F_FULL:    return 32'(full);
      F_STALL:   return 32'(stall);
      F_UE:      return 32'(ue);
      F_STATE:   return 32'(state);
      F_DRAINED: return 32'(drained);
      F_SC:      return 32'(stall_cycles);
      F_BC:      return 32'(bubble_cycles);
      default:   return 32'hdead_beef;
    endcase
  endfunction

  // Monitor: the outputs are valid every cycle, so every queued entry due now is checked.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e   = sb.pop_front();
      mon_act = read_field(mon_e.field);
      checks++;
      if (mon_e.cyc != cyc || mon_act !== mon_e.val) begin
        errors++;
        $display("FAIL %s (cycle %0d): got %0h, expected %0h", mon_e.name, mon_e.cyc, mon_act,
                 mon_e.val);
      end
    end
  end

  task automatic push_exp(input string name, input int field, input logic [31:0] val);
    exp_t e;
    e.cyc   = cyc;
    e.name  = name;
    e.field = field;
    e.val   = val;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; haz = '0; flush = '0; drain_req = 1'b0; resume = 1'b0; cnt_clr = 1'b0;
    step();
    push_exp("rst_full", F_FULL, 0);
    push_exp("rst_state", F_STATE, 0);
    push_exp("rst_stall", F_STALL, 0);
    push_exp("rst_ue", F_UE, 0);
    push_exp("rst_drained", F_DRAINED, 0);
    push_exp("rst_sc", F_SC, 0);
    push_exp("rst_bc", F_BC, 0);
    step();
    rst_n = 1'b1;
    push_exp("fill0", F_FULL, 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      push_exp($sformatf("fill%0d", k), F_FULL, (32'd1 << k) - 1);
    end
    push_exp("fill_bc", F_BC, 5);
    push_exp("fill_sc", F_SC, 0);

    // Hazard on stage 2 for two cycles
    haz = 5'b00100;
    push_exp("haz_stall1", F_STALL, 5'b00111);
    push_exp("haz_ue1", F_UE, 5'b11000);
    step();
    push_exp("haz_full1", F_FULL, 5'b10111);
    push_exp("haz_stall2", F_STALL, 5'b00111);
    push_exp("haz_ue2", F_UE, 5'b10000);
    step();
    haz = '0;
    push_exp("haz_full2", F_FULL, 5'b00111);
    push_exp("haz_sc", F_SC, 2);
    push_exp("haz_stall_off", F_STALL, 0);
    step();
    push_exp("refill1", F_FULL, 5'b01111);
    step();
    push_exp("refill2", F_FULL, 5'b11111);
    push_exp("refill_bc", F_BC, 7);

    // Flush of stages 0..1 masks a hazard on a flushed stage
    flush = 5'b00011;
    haz   = 5'b00010;
    push_exp("flush_stall", F_STALL, 0);
    push_exp("flush_ue", F_UE, 5'b11100);
    step();
    flush = '0;
    haz   = '0;
    push_exp("flush_full", F_FULL, 5'b11001);
    repeat (4) step();
    push_exp("flush_refill", F_FULL, 5'b11111);

    // Drain / halt / resume
    drain_req = 1'b1;
    push_exp("drn_state0", F_STATE, 0);
    step();
    drain_req = 1'b0;
    push_exp("drn_state1", F_STATE, 1);
    push_exp("drn_full1", F_FULL, 5'b11111);
    step();
    resume = 1'b1;
    push_exp("drn_full2", F_FULL, 5'b11110);
    step();
    resume = 1'b0;
    push_exp("drn_full3", F_FULL, 5'b11100);
    push_exp("drn_resume_ign", F_STATE, 1);
    step();
    push_exp("drn_full4", F_FULL, 5'b11000);
    step();
    push_exp("drn_full5", F_FULL, 5'b10000);
    step();
    push_exp("drn_full6", F_FULL, 0);
    push_exp("drn_state6", F_STATE, 1);
    push_exp("drn_drained6", F_DRAINED, 0);
    step();
    push_exp("halt_state", F_STATE, 2);
    push_exp("halt_drained", F_DRAINED, 1);
    drain_req = 1'b1;
    resume    = 1'b1;
    step();
    drain_req = 1'b0;
    resume    = 1'b0;
    push_exp("resume_state", F_STATE, 0);
    push_exp("resume_full", F_FULL, 0);
    step();
    push_exp("resume_fetch", F_FULL, 5'b00001);
    repeat (4) step();
    push_exp("resume_refill", F_FULL, 5'b11111);

    // Counter saturation and clear
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    push_exp("clr_sc", F_SC, 0);
    push_exp("clr_bc", F_BC, 0);
    haz = 5'b10000;
    push_exp("sat_stall", F_STALL, 5'b11111);
    push_exp("sat_ue", F_UE, 0);
    repeat (14) step();
    push_exp("sat_sc14", F_SC, 14);
    push_exp("sat_full", F_FULL, 5'b11111);
    repeat (6) step();
    push_exp("sat_sc15", F_SC, 15);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    push_exp("clr_sat_sc", F_SC, 0);
    push_exp("clr_sat_stall", F_STALL, 5'b11111);

    // Async reset while stalled in DRAIN
    drain_req = 1'b1;
    step();
    drain_req = 1'b0;
    push_exp("sdrn_state", F_STATE, 1);
    push_exp("sdrn_full", F_FULL, 5'b11111);
    push_exp("sdrn_sc1", F_SC, 1);
    step();
    push_exp("sdrn_sc2", F_SC, 2);
    push_exp("sdrn_state2", F_STATE, 1);
    step();
    rst_n = 1'b0;
    push_exp("arst_full", F_FULL, 0);
    push_exp("arst_state", F_STATE, 0);
    push_exp("arst_sc", F_SC, 0);
    push_exp("arst_stall", F_STALL, 0);
    haz = '0;
    step();
    rst_n = 1'b1;
    push_exp("post_full0", F_FULL, 0);
    step();
    push_exp("post_full1", F_FULL, 5'b00001);
    step();
    push_exp("post_full2", F_FULL, 5'b00011);
    push_exp("post_bc", F_BC, 2);

    step();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
